tlp_cpl_responder: RTL and testbench

TLP_CPL_RESPONDER -- requirements
Module: tlp_cpl_responder

---
 rtl/tlp_cpl_responder.sv | 218 +++++++++++++++++++++
 tb/tb_tlp_cpl_responder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlp_cpl_responder.sv
// PCIe target responder: answers 1-DW MRd32 from NUM_REGS 32-bit registers and drains all other TLPs.
// Define TLP_MWR_EN to also accept 1-DW MWr32 writes into the register bank.
module tlp_cpl_responder #(
    parameter int NUM_REGS = 16
) (
    input  logic        pcieClk_in,
    input  logic        pcieReset_in,
    input  logic [12:0] cfgBusDev_in,
    input  logic [63:0] rxData_in,
    input  logic        rxSOP_in,
    input  logic        rxEOP_in,
    input  logic        rxValid_in,
    output logic        rxReady_out,
    output logic [63:0] txData_out,
    output logic        txSOP_out,
    output logic        txEOP_out,
    output logic        txValid_out,
    input  logic        txReady_in,
    output logic [31:0] reg0_out
);

    localparam int          IDX_W   = $clog2(NUM_REGS);
    localparam logic [31:0] CPL_DW0 = 32'h4A00_0001;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR1  = 3'd1,
        WDATA = 3'd2,
        CPL0  = 3'd3,
        CPL1  = 3'd4,
        CPL2  = 3'd5,
        DRAIN = 3'd6
    } state_t;

    state_t state, state_nxt;

    logic             rx_en;
    logic [7:0]       fmt_type_q;
    logic [9:0]       len_q;
    logic [15:0]      req_id_q;
    logic [7:0]       tag_q;
    logic [3:0]       first_be_q;
    logic [6:2]       addr_q;
    logic             rd_pend_q;
    logic [31:0]      cpl_data_q;
    logic [31:0]      regs [NUM_REGS];

    logic             rx_fire;
    logic             is_rd;
    logic             hdr_load, addr_load, cpl_load, pend_set, pend_clr;
    logic [IDX_W-1:0] cur_idx;
    logic [31:0]      cpl_dw1, cpl_dw2;
    logic             unused_rx;

`ifdef TLP_MWR_EN
    logic             is_wr;
    logic             reg_we;
    logic [31:0]      reg_wdata;

    assign is_wr = (fmt_type_q == 8'h40) && (len_q == 10'd1);
`endif

    // TC/attr/TD/EP/AT bits of DW0 and last-BE of DW1 carry no meaning here.
    assign unused_rx = ^{rxData_in[23:10], rxData_in[39:36]};

    assign is_rd       = (fmt_type_q == 8'h00) && (len_q == 10'd1) && (first_be_q != 4'h0);
    assign rxReady_out = rx_en && (state == IDLE || state == HDR1 || state == WDATA || state == DRAIN);
    assign rx_fire     = rxValid_in && rxReady_out;
    assign cur_idx     = (state == HDR1) ? rxData_in[IDX_W+1:2] : addr_q[IDX_W+1:2];
    assign cpl_dw1     = {cfgBusDev_in, 3'b000, 16'h0004};
    assign cpl_dw2     = {req_id_q, tag_q, 1'b0, addr_q, 2'b00};
    assign reg0_out    = regs[0];

    always_ff @(posedge pcieClk_in or posedge pcieReset_in) begin
        if (pcieReset_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        hdr_load    = 1'b0;
        addr_load   = 1'b0;
        cpl_load    = 1'b0;
        pend_set    = 1'b0;
        pend_clr    = 1'b0;
        txValid_out = 1'b0;
        txSOP_out   = 1'b0;
        txEOP_out   = 1'b0;
        txData_out  = '0;
`ifdef TLP_MWR_EN
        reg_we      = 1'b0;
        reg_wdata   = rxData_in[31:0];
`endif
        case (state)
            IDLE: begin
                // A lone SOP+EOP beat cannot hold a 3DW header, so it is dropped too.
                if (rx_fire && rxSOP_in && !rxEOP_in) begin
                    hdr_load  = 1'b1;
                    state_nxt = HDR1;
                end
            end
            HDR1: begin
                if (rx_fire) begin
                    addr_load = 1'b1;
                    if (is_rd) begin
                        if (rxEOP_in) begin
                            cpl_load  = 1'b1;
                            state_nxt = CPL0;
                        end else begin
                            pend_set  = 1'b1;
                            state_nxt = DRAIN;
                        end
                    end
`ifdef TLP_MWR_EN
                    else if (is_wr) begin
                        if (rxData_in[2]) begin
                            reg_we    = 1'b1;
                            reg_wdata = rxData_in[63:32];
                            state_nxt = rxEOP_in ? IDLE : DRAIN;
                        end else begin
                            state_nxt = rxEOP_in ? IDLE : WDATA;
                        end
                    end
`endif
                    else begin
                        state_nxt = rxEOP_in ? IDLE : DRAIN;
                    end
                end
            end
`ifdef TLP_MWR_EN
            WDATA: begin
                if (rx_fire) begin
                    reg_we    = 1'b1;
                    reg_wdata = rxData_in[31:0];
                    state_nxt = rxEOP_in ? IDLE : DRAIN;
                end
            end
`endif
            DRAIN: begin
                if (rx_fire && rxEOP_in) begin
                    if (rd_pend_q) begin
                        cpl_load  = 1'b1;
                        pend_clr  = 1'b1;
                        state_nxt = CPL0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            CPL0: begin
                txValid_out = 1'b1;
                txSOP_out   = 1'b1;
                txData_out  = {cpl_dw1, CPL_DW0};
                if (txReady_in) state_nxt = CPL1;
            end
            CPL1: begin
                txValid_out = 1'b1;
                txEOP_out   = addr_q[2];
                txData_out  = addr_q[2] ? {cpl_data_q, cpl_dw2} : {32'h0, cpl_dw2};
                if (txReady_in) state_nxt = addr_q[2] ? IDLE : CPL2;
            end
            CPL2: begin
                txValid_out = 1'b1;
                txEOP_out   = 1'b1;
                txData_out  = {32'h0, cpl_data_q};
                if (txReady_in) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pcieClk_in or posedge pcieReset_in) begin
        if (pcieReset_in) begin
            rx_en      <= 1'b0;
            fmt_type_q <= '0;
            len_q      <= '0;
            req_id_q   <= '0;
            tag_q      <= '0;
            first_be_q <= '0;
            addr_q     <= '0;
            rd_pend_q  <= 1'b0;
            cpl_data_q <= '0;
        end else begin
            rx_en <= 1'b1;
            if (hdr_load) begin
                fmt_type_q <= rxData_in[31:24];
                len_q      <= rxData_in[9:0];
                req_id_q   <= rxData_in[63:48];
                tag_q      <= rxData_in[47:40];
                first_be_q <= rxData_in[35:32];
            end
            if (addr_load) addr_q <= rxData_in[6:2];
            if (pend_set) begin
                rd_pend_q <= 1'b1;
            end else if (pend_clr) begin
                rd_pend_q <= 1'b0;
            end
            if (cpl_load) cpl_data_q <= regs[cur_idx];
        end
    end

    always_ff @(posedge pcieClk_in or posedge pcieReset_in) begin
        if (pcieReset_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 32'hCAFE_0000 | 32'(i);
            end
        end
`ifdef TLP_MWR_EN
        else if (reg_we) begin
            regs[cur_idx] <= reg_wdata;
        end
`endif
    end

endmodule

// File: tb/tb_tlp_cpl_responder.sv
// Scoreboard bench for tlp_cpl_responder: a request-level model pushes expected CplD beats,
// a negedge monitor pops and compares every accepted output beat.
module tb_tlp_cpl_responder;

    localparam int NR = 16;
`ifdef TLP_MWR_EN
    localparam bit MWR = 1'b1;
`else
    localparam bit MWR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] bus_dev;
    logic [63:0] rx_data;
    logic        rx_sop, rx_eop, rx_valid;
    logic        rx_ready;
    logic [63:0] tx_data;
    logic        tx_sop, tx_eop, tx_valid;
    logic        tx_ready;
    logic [31:0] reg0;

    logic        tx_rand = 1'b0;
    logic        tx_rand_val = 1'b1;
    logic        tx_manual = 1'b1;
    logic        rx_gap = 1'b0;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [65:0] exp_q [$];
    logic [31:0] model_regs [NR];

    tlp_cpl_responder #(.NUM_REGS(NR)) dut (
        .pcieClk_in   (clk),
        .pcieReset_in (rst),
        .cfgBusDev_in (bus_dev),
        .rxData_in    (rx_data),
        .rxSOP_in     (rx_sop),
        .rxEOP_in     (rx_eop),
        .rxValid_in   (rx_valid),
        .rxReady_out  (rx_ready),
        .txData_out   (tx_data),
        .txSOP_out    (tx_sop),
        .txEOP_out    (tx_eop),
        .txValid_out  (tx_valid),
        .txReady_in   (tx_ready),
        .reg0_out     (reg0)
    );

    assign tx_ready = tx_rand ? tx_rand_val : tx_manual;

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            tx_rand_val = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "time limit reached");
    end

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Output monitor: every accepted beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_beat: got %h, expected no beat", {tx_sop, tx_eop, tx_data});
            end else begin
                check("cpl_beat", {tx_sop, tx_eop, tx_data}, exp_q.pop_front());
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < NR; i++) model_regs[i] = 32'hCAFE_0000 | 32'(i);
    endtask

    task automatic model_tlp(input logic [7:0] ft, input logic [9:0] len, input logic [15:0] rid,
                             input logic [7:0] tag, input logic [3:0] fbe, input logic [31:0] addr,
                             input logic [31:0] data);
        int          idx;
        logic [31:0] d1, d2, rd;
        idx = int'(addr[31:2] % 30'(NR));
        if (ft == 8'h00 && len == 10'd1 && fbe != 4'h0) begin
            rd = model_regs[idx];
            d1 = {bus_dev, 3'b000, 16'h0004};
            d2 = {rid, tag, 1'b0, addr[6:2], 2'b00};
            exp_q.push_back({2'b10, d1, 32'h4A00_0001});
            if (addr[2]) begin
                exp_q.push_back({2'b01, rd, d2});
            end else begin
                exp_q.push_back({2'b00, 32'h0, d2});
                exp_q.push_back({2'b01, 32'h0, rd});
            end
        end else if (MWR && ft == 8'h40 && len == 10'd1) begin
            model_regs[idx] = data;
        end
    endtask

    task automatic send_beat(input logic [63:0] d, input logic sop, input logic eop);
        int guard;
        if (rx_gap) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rx_data  = d;
        rx_sop   = sop;
        rx_eop   = eop;
        rx_valid = 1'b1;
        guard    = 0;
        @(negedge clk);
        while (!rx_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!rx_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL rx_accept_timeout: got rxReady_out=0, expected 1");
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_sop   = 1'b0;
        rx_eop   = 1'b0;
        rx_data  = '0;
    endtask

    task automatic send_tlp(input logic [7:0] ft, input logic [9:0] len, input logic [15:0] rid,
                            input logic [7:0] tag, input logic [3:0] fbe, input logic [31:0] addr,
                            input logic [31:0] data, input int extra);
        logic [31:0] dw0, dw1;
        logic        wbeat;
        model_tlp(ft, len, rid, tag, fbe, addr, data);
        dw0   = {ft, 14'($urandom), len};
        dw1   = {rid, tag, 4'($urandom), fbe};
        wbeat = (ft == 8'h40) && !addr[2];
        send_beat({dw1, dw0}, 1'b1, 1'b0);
        send_beat({addr[2] ? data : 32'($urandom), addr}, 1'b0, !wbeat && extra == 0);
        if (wbeat) send_beat({32'($urandom), data}, 1'b0, extra == 0);
        for (int i = 0; i < extra; i++) send_beat({32'($urandom), 32'($urandom)}, 1'b0, i == extra - 1);
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 1000) begin
            @(posedge clk);
            g++;
        end
        check("drain_complete", 66'(exp_q.size()), 66'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  ft;
        logic [9:0]  len;
        logic [3:0]  fbe;
        logic [31:0] addr;
        int          extra;

        rx_data  = '0;
        rx_sop   = 1'b0;
        rx_eop   = 1'b0;
        rx_valid = 1'b0;
        bus_dev  = 13'h0008;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_ready", 66'(rx_ready), 66'd0);
        check("rst_tx_ctrl", 66'({tx_valid, tx_sop, tx_eop}), 66'd0);
        check("rst_tx_data", 66'(tx_data), 66'd0);
        check("rst_reg0", 66'(reg0), 66'(model_regs[0]));
        rst = 1'b0;
        #1;
        check("ready_before_clock", 66'(rx_ready), 66'd0);
        @(posedge clk);
        #1;
        check("ready_first_clock", 66'(rx_ready), 66'd1);

        // Reference read, write then read-back, write to register 0.
        send_tlp(8'h00, 10'd1, 16'h0100, 8'h05, 4'hF, 32'h0000_0008, 32'h0, 0);
        wait_drain();
        send_tlp(8'h40, 10'd1, 16'h0100, 8'h06, 4'hF, 32'h0000_0004, 32'h1234_5678, 0);
        send_tlp(8'h00, 10'd1, 16'h0100, 8'h07, 4'hF, 32'h0000_0004, 32'h0, 0);
        wait_drain();
        send_tlp(8'h40, 10'd1, 16'h0200, 8'h08, 4'hF, 32'h0000_0000, 32'hA5A5_A5A5, 0);
        check("reg0_after_write", 66'(reg0), 66'(model_regs[0]));

        // Unsupported / drained traffic followed by valid reads.
        send_tlp(8'h00, 10'd2, 16'h0300, 8'h09, 4'hF, 32'h0000_0008, 32'h0, 1);
        send_tlp(8'h00, 10'd1, 16'h0300, 8'h0A, 4'hF, 32'h0000_000C, 32'h0, 0);
        send_tlp(8'h00, 10'd1, 16'h0300, 8'h0B, 4'h0, 32'h0000_0010, 32'h0, 0);
        send_tlp(8'h20, 10'd1, 16'h0300, 8'h0C, 4'hF, 32'h0000_0010, 32'h0, 1);
        send_tlp(8'h4A, 10'd1, 16'h0300, 8'h0D, 4'hF, 32'h0000_0010, 32'h0, 0);
        send_tlp(8'h40, 10'd3, 16'h0300, 8'h0E, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 2);
        send_beat(64'h1111_2222_3333_4444, 1'b0, 1'b1);
        send_tlp(8'h00, 10'd1, 16'h0300, 8'h0F, 4'hF, 32'h0000_0010, 32'h0, 0);
        send_tlp(8'h00, 10'd1, 16'h0300, 8'h10, 4'h1, 32'hFFFF_FFC0, 32'h0, 0);
        send_tlp(8'h00, 10'd1, 16'h0300, 8'h11, 4'hF, 32'h0000_0014, 32'h0, 2);
        send_tlp(8'h40, 10'd1, 16'h0300, 8'h12, 4'hF, 32'h0000_0018, 32'h0BAD_F00D, 1);
        send_tlp(8'h00, 10'd1, 16'h0300, 8'h13, 4'hF, 32'h0000_0018, 32'h0, 0);
        wait_drain();
        check("reg0_after_drains", 66'(reg0), 66'(model_regs[0]));

        // Backpressure held for five cycles in the second completion beat.
        send_tlp(8'h00, 10'd1, 16'h0400, 8'h20, 4'hF, 32'h0000_0008, 32'h0, 0);
        @(posedge clk);
        #1;
        tx_manual = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_beat", {tx_sop, tx_eop, tx_data}, exp_q.size() != 0 ? exp_q[0] : 66'h0);
            check("hold_valid", 66'(tx_valid), 66'd1);
            check("hold_rx_ready", 66'(rx_ready), 66'd0);
        end
        @(posedge clk);
        #1;
        tx_manual = 1'b1;
        wait_drain();

        // Reset pulse in the middle of a completion.
        send_tlp(8'h00, 10'd1, 16'h0500, 8'h21, 4'hF, 32'h0000_0008, 32'h0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_tx_ctrl", 66'({tx_valid, tx_sop, tx_eop}), 66'd0);
        check("abort_tx_data", 66'(tx_data), 66'd0);
        check("abort_rx_ready", 66'(rx_ready), 66'd0);
        exp_q.delete();
        model_reset();
        @(posedge clk);
        #1;
        check("abort_reg0", 66'(reg0), 66'(model_regs[0]));
        rst = 1'b0;
        #1;
        check("rerelease_ready_low", 66'(rx_ready), 66'd0);
        @(posedge clk);
        #1;
        check("rerelease_ready_high", 66'(rx_ready), 66'd1);
        send_tlp(8'h00, 10'd1, 16'h0500, 8'h22, 4'hF, 32'h0000_000C, 32'h0, 0);
        wait_drain();

        // Randomized traffic with random sink backpressure and source gaps.
        tx_rand = 1'b1;
        rx_gap  = 1'b1;
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 7))
                0, 1, 2: ft = 8'h00;
                3, 4:    ft = 8'h40;
                5:       ft = 8'h20;
                6:       ft = 8'h4A;
                default: ft = 8'h60;
            endcase
            len   = ($urandom_range(0, 4) == 0) ? 10'($urandom) : 10'd1;
            fbe   = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            addr  = $urandom;
            extra = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2)) : 0;
            if ($urandom_range(0, 9) == 0) send_beat({32'($urandom), 32'($urandom)}, 1'b0, 1'($urandom));
            send_tlp(ft, len, 16'($urandom), 8'($urandom), fbe, addr, $urandom, extra);
            if (n % 25 == 24) begin
                wait_drain();
                check("reg0_random", 66'(reg0), 66'(model_regs[0]));
                bus_dev = 13'($urandom);
            end
        end
        tx_rand = 1'b0;
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
